reconstructor_dividendo: RTL and testbench
==========================================

RECONSTRUCTOR_DIVIDENDO -- requirements
Module: reconstructor_dividendo

Interface
REQ-001 Parameter: tamanyo, default 32, operand width in bits.
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 RST_N  input  1  synchronous, active-low reset, sampled on CLK rising edge.
REQ-004 START  input  1  request pulse; operands sampled on the same edge.
REQ-005 COC  input  tamanyo  quotient (unsigned).
REQ-006 DENOMINADOR  input  tamanyo  divisor (unsigned).
REQ-007 RES  input  tamanyo  remainder (unsigned).
REQ-008 NUMERADOR  output  2*tamanyo  reconstructed dividend COC*DENOMINADOR+RES.
REQ-009 DONE  output  1  one-cycle result-valid strobe.
REQ-010 BUSY  output  1  high while a computation is in progress.
REQ-011 RES_INVALIDO  output  1  high with DONE when the operand triple is not a legal division result.

Function
REQ-012 Block SHALL be the inverse of the team's divider: computes NUMERADOR = COC*DENOMINADOR + RES, exact, unsigned, no truncation (result always fits 2*tamanyo bits).
REQ-013 FSM SHALL have three states: IDLE, CALC, FIN.
REQ-014 IDLE: START=1 -> latch COC, DENOMINADOR, RES; accumulator := RES zero-extended to 2*tamanyo; shifted denominator := DENOMINADOR zero-extended; iteration counter := 0; go CALC.
REQ-015 CALC: per cycle, if latched-quotient LSB=1 add shifted denominator to accumulator; shift denominator left 1; shift latched quotient right 1; counter +1.
REQ-016 CALC SHALL last exactly tamanyo cycles, then go FIN; counter width ceil(log2(tamanyo))+1, no wrap before terminal count.
REQ-017 FIN: DONE=1 for exactly one cycle; NUMERADOR shows final accumulator; next state IDLE, or CALC if START=1 in FIN (back-to-back accepted, new operands latched per REQ-014).
REQ-018 Latency: DONE SHALL be high in the cycle beginning tamanyo+1 rising edges after the edge sampling START (33 for tamanyo=32).
REQ-019 NUMERADOR SHALL be registered and hold its value from FIN until the next FIN; it SHALL NOT expose intermediate accumulator values.
REQ-020 BUSY SHALL be 1 in CALC, 0 in IDLE and FIN.
REQ-021 START while in CALC SHALL be ignored; latched operands SHALL be unaffected.
REQ-022 Input changes on COC/DENOMINADOR/RES outside the accepting edge SHALL NOT affect the result.
REQ-023 RES_INVALIDO SHALL be computed from latched operands as (RES >= DENOMINADOR), covering DENOMINADOR=0; registered, valid only while DONE=1, 0 otherwise.
REQ-024 Invalid operands SHALL NOT abort the computation; NUMERADOR is still the exact arithmetic result.

Reset
REQ-025 RST_N=0 at a rising edge SHALL force state IDLE, NUMERADOR=0, DONE=0, BUSY=0, RES_INVALIDO=0, clear counter and internal registers.
REQ-026 Reset SHALL take priority over START and over any in-progress computation; an aborted computation SHALL NOT produce DONE.
REQ-027 First START accepted is the first edge with RST_N=1 and START=1.

Verification
REQ-028 tamanyo=32, COC=7, DENOMINADOR=3, RES=2, START one cycle -> DONE 33 edges later, NUMERADOR=23, RES_INVALIDO=0, BUSY high for 32 cycles.
REQ-029 COC=0xFFFFFFFF, DENOMINADOR=0xFFFFFFFF, RES=0xFFFFFFFE -> NUMERADOR=0xFFFFFFFE_FFFFFFFF, RES_INVALIDO=0.
REQ-030 COC=5, DENOMINADOR=0, RES=0 -> NUMERADOR=0, RES_INVALIDO=1; COC=4, DENOMINADOR=3, RES=3 -> NUMERADOR=15, RES_INVALIDO=1.
REQ-031 START with (7,3,2), then START with (1,1,0) 10 cycles later -> single DONE at edge 33, NUMERADOR=23; no second DONE.
REQ-032 RST_N=0 for one edge at CALC cycle 10 -> next cycle BUSY=0, DONE=0, NUMERADOR=0, no DONE follows; subsequent START (2,5,1) -> NUMERADOR=11 after 33 edges.
REQ-033 START held high through the DONE cycle with (7,3,2) then (2,5,1) -> DONE with 23, then DONE with 11 exactly 33 edges later; randomized 1000-run self-check against COC*DENOMINADOR+RES and against the divider output of the team's divisor (round trip).

Source files
------------

// File: rtl/reconstructor_dividendo_if.sv
// Request/result bundle for the dividend reconstructor: operands in, dividend and status out.
interface reconstructor_dividendo_if #(
  parameter int tamanyo = 32
);
  logic                   start;
  logic [tamanyo-1:0]     coc;
  logic [tamanyo-1:0]     denominador;
  logic [tamanyo-1:0]     res;
  logic [2*tamanyo-1:0]   numerador;
  logic                   done;
  logic                   busy;
  logic                   res_invalido;

  modport master (
    output start, coc, denominador, res,
    input  numerador, done, busy, res_invalido
  );

  modport slave (
    input  start, coc, denominador, res,
    output numerador, done, busy, res_invalido
  );
endinterface

// File: rtl/reconstructor_dividendo.sv
// Rebuilds a dividend as coc*denominador+res with a serial shift-and-add multiplier
// (one quotient bit per cycle), flagging operand triples a divider could not produce.
module reconstructor_dividendo #(
  parameter int tamanyo = 32
) (
  input  logic clk,
  input  logic rst_n,
  reconstructor_dividendo_if.slave bus
);
  localparam int cnt_w = $clog2(tamanyo) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t                 state_reg;
  logic [tamanyo-1:0]     coc_reg;
  logic [tamanyo-1:0]     den_reg;
  logic [tamanyo-1:0]     res_reg;
  logic [2*tamanyo-1:0]   acc_reg;
  logic [2*tamanyo-1:0]   den_sh_reg;
  logic [2*tamanyo-1:0]   numerador_reg;
  logic [cnt_w-1:0]       cnt_reg;
  logic                   done_reg;
  logic                   busy_reg;
  logic                   invalido_reg;
  logic                   accept;

  // Requests are only taken when idle or in the final cycle (back-to-back).
  assign accept = bus.start && (state_reg == IDLE || state_reg == FIN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      coc_reg       <= '0;
      den_reg       <= '0;
      res_reg       <= '0;
      acc_reg       <= '0;
      den_sh_reg    <= '0;
      numerador_reg <= '0;
      cnt_reg       <= '0;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      invalido_reg  <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      invalido_reg <= 1'b0;

      // The FIN cycle publishes the result; done/numerador appear on the following cycle.
      if (state_reg == FIN) begin
        done_reg      <= 1'b1;
        numerador_reg <= acc_reg;
        invalido_reg  <= (res_reg >= den_reg);
      end

      if (accept) begin
        coc_reg    <= bus.coc;
        den_reg    <= bus.denominador;
        res_reg    <= bus.res;
        acc_reg    <= {{tamanyo{1'b0}}, bus.res};
        den_sh_reg <= {{tamanyo{1'b0}}, bus.denominador};
        cnt_reg    <= '0;
        busy_reg   <= 1'b1;
        state_reg  <= CALC;
      end else begin
        case (state_reg)
          IDLE: begin
            busy_reg <= 1'b0;
          end
          CALC: begin
            if (coc_reg[0])
              acc_reg <= acc_reg + den_sh_reg;
            den_sh_reg <= den_sh_reg << 1;
            coc_reg    <= coc_reg >> 1;
            cnt_reg    <= cnt_reg + 1'b1;
            if (cnt_reg == cnt_w'(tamanyo - 1)) begin
              busy_reg  <= 1'b0;
              state_reg <= FIN;
            end
          end
          FIN: begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
          default: begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.numerador    = numerador_reg;
  assign bus.done         = done_reg;
  assign bus.busy         = busy_reg;
  assign bus.res_invalido = invalido_reg;
endmodule

// File: tb/tb_reconstructor_dividendo.sv
// Scoreboard bench for reconstructor_dividendo: expected dividends queued at request time,
// checked (value, invalid flag, latency) whenever done pulses.
module tb_reconstructor_dividendo;
  localparam int T = 32;

  typedef struct {
    logic [63:0] num;
    logic        inv;
    int unsigned due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reconstructor_dividendo_if #(.tamanyo(T)) bus ();
  reconstructor_dividendo #(.tamanyo(T)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  // Result monitor: every done must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(bus.done), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        $display("txn cyc=%0d numerador=0x%016h res_invalido=%0b", cyc, bus.numerador, bus.res_invalido);
        check("numerador", bus.numerador, mon_e.num);
        check("res_invalido", 64'(bus.res_invalido), 64'(mon_e.inv));
        check("latency", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  task automatic push_exp(input logic [63:0] num, input logic inv, input int unsigned due);
    exp_t e;
    e.num = num;
    e.inv = inv;
    e.due = due;
    sb.push_back(e);
  endtask

  // One-cycle request; operands are scrambled afterwards so late changes must not matter.
  task automatic run_op(input logic [31:0] c, input logic [31:0] d, input logic [31:0] r,
                        input bit push, input logic [63:0] exp_num, input logic exp_inv);
    @(negedge clk);
    bus.start = 1'b1;
    bus.coc = c;
    bus.denominador = d;
    bus.res = r;
    @(posedge clk);
    #1;
    if (push) push_exp(exp_num, exp_inv, cyc + 33);
    @(negedge clk);
    bus.start = 1'b0;
    bus.coc = $urandom;
    bus.denominador = $urandom;
    bus.res = $urandom;
  endtask

  task automatic run_model(input logic [31:0] c, input logic [31:0] d, input logic [31:0] r);
    run_op(c, d, r, 1'b1, 64'(c) * 64'(d) + 64'(r), (r >= d));
  endtask

  task automatic wait_drain(input int extra);
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    repeat (extra) @(negedge clk);
  endtask

  initial begin
    int bc;
    int k;
    int unsigned d1;
    logic [31:0] q, d, r, lo, hi;
    logic [63:0] n;

    bus.start = 1'b0;
    bus.coc = '0;
    bus.denominador = '0;
    bus.res = '0;

    // Reset, with a start request that must be ignored while reset is asserted
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.coc = 32'd9;
    bus.denominador = 32'd9;
    @(negedge clk);
    check("rst_numerador", bus.numerador, 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_invalido", 64'(bus.res_invalido), 64'd0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 64'(bus.busy), 64'd0);

    // Basic case with busy duration
    run_model(32'd7, 32'd3, 32'd2);
    bc = bus.busy ? 1 : 0;
    repeat (39) begin
      @(negedge clk);
      bc += bus.busy ? 1 : 0;
    end
    check("busy_cycles", 64'(bc), 64'd32);
    check("hold_numerador", bus.numerador, 64'd23);
    wait_drain(2);

    // Extremes and invalid triples
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 64'hFFFF_FFFE_FFFF_FFFF, 1'b0);
    wait_drain(2);
    run_op(32'd5, 32'd0, 32'd0, 1'b1, 64'd0, 1'b1);
    wait_drain(2);
    run_op(32'd4, 32'd3, 32'd3, 1'b1, 64'd15, 1'b1);
    wait_drain(2);

    // Start during CALC is ignored
    run_model(32'd7, 32'd3, 32'd2);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.coc = 32'd1;
    bus.denominador = 32'd1;
    bus.res = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain(40);

    // Reset in the middle of CALC aborts without done
    run_op(32'd7, 32'd3, 32'd2, 1'b0, 64'd0, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_numerador", bus.numerador, 64'd0);
    repeat (40) @(negedge clk);
    run_model(32'd2, 32'd5, 32'd1);
    wait_drain(2);

    // Back-to-back: start held high through the done cycle
    @(negedge clk);
    bus.start = 1'b1;
    bus.coc = 32'd7;
    bus.denominador = 32'd3;
    bus.res = 32'd2;
    @(posedge clk);
    #1;
    d1 = cyc + 33;
    push_exp(64'd23, 1'b0, d1);
    push_exp(64'd11, 1'b0, d1 + 33);
    @(negedge clk);
    bus.coc = 32'd2;
    bus.denominador = 32'd5;
    bus.res = 32'd1;
    k = 0;
    while (!bus.done && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("b2b_first_done_seen", 64'(bus.done), 64'd1);
    bus.start = 1'b0;
    wait_drain(2);

    // Randomized runs: division round trips and arbitrary triples
    for (int i = 0; i < 1000; i++) begin
      if (i % 2 == 0) begin
        d = $urandom;
        if (d == 0) d = 32'd1;
        hi = $urandom % d;
        lo = $urandom;
        n = {hi, lo};
        q = 32'(n / 64'(d));
        r = 32'(n % 64'(d));
        run_op(q, d, r, 1'b1, n, 1'b0);
      end else begin
        q = $urandom;
        d = (i % 4 == 1) ? 32'($urandom_range(0, 15)) : $urandom;
        r = (i % 4 == 1) ? 32'($urandom_range(0, 15)) : $urandom;
        run_model(q, d, r);
      end
      wait_drain(0);
    end
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
